sr_flag_arbiter: RTL and testbench



---
 rtl/sr_flag_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sr_flag_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_flag_arbiter.sv
// ----------------------------------------------------------------------------
// sr_flag_arbiter
// Shared controller for a bank of SR status flags. Two requesters (A, B) ask
// to set, clear or hold one flag through a req/ack handshake. Requests are
// arbitrated round-robin and served one at a time, so a flag never sees
// S and R asserted together.
//
// Optional build macro: SR_FLAG_ARBITER_TOGGLE_EN
//   defined   : op 11 toggles the addressed flag (JK style); Err only for a
//               bad index.
//   undefined : op 11 is rejected; flag holds and Err pulses.
//
// Parameters
//   N_FLAGS : number of flags in the bank (2..2**IDX_W)
//   IDX_W   : width of the flag index inputs
//
// Ports
//   Clk, Rst_n         : clock, asynchronous active-low reset
//   Req_A/Op_A/Idx_A   : requester A handshake request, operation, index
//   Ack_A              : one-cycle completion pulse to A
//   Req_B/Op_B/Idx_B   : requester B, same as A
//   Ack_B              : one-cycle completion pulse to B
//   Flags              : registered flag states (Q)
//   Flags_bar          : combinational complement of Flags
//   Err                : one-cycle pulse alongside Ack when the op was rejected
//   Busy               : high whenever the controller is not idle
// ----------------------------------------------------------------------------
module sr_flag_arbiter #(
    parameter int unsigned N_FLAGS = 8,
    parameter int unsigned IDX_W   = 3
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Req_A,
    input  logic [1:0]         Op_A,
    input  logic [IDX_W-1:0]   Idx_A,
    output logic               Ack_A,
    input  logic               Req_B,
    input  logic [1:0]         Op_B,
    input  logic [IDX_W-1:0]   Idx_B,
    output logic               Ack_B,
    output logic [N_FLAGS-1:0] Flags,
    output logic [N_FLAGS-1:0] Flags_bar,
    output logic               Err,
    output logic               Busy
);

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_BOTH = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_APPLY   = 2'd1,
        S_ACK     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_last_b;   // last grant went to B
    logic               r_gnt_b;    // current transaction belongs to B
    logic [1:0]         r_op;
    logic [IDX_W-1:0]   r_idx;
    logic [N_FLAGS-1:0] r_flags;
    logic               r_ack_a;
    logic               r_ack_b;
    logic               r_err;

    logic               w_req_any;
    logic               w_grant_b;
    logic               w_gnt_req;
    logic               w_in_range;
    logic               w_op_err;
    logic               w_err;
    logic [N_FLAGS-1:0] w_next_flags;

    // Round-robin pick: B wins alone, or on a tie when A was served last.
    assign w_req_any = Req_A | Req_B;
    assign w_grant_b = Req_B & (~Req_A | ~r_last_b);

    // Req of the requester currently holding the grant.
    assign w_gnt_req = r_gnt_b ? Req_B : Req_A;

    // Widen before comparing so N_FLAGS == 2**IDX_W does not wrap to zero.
    assign w_in_range = (32'(r_idx) < N_FLAGS);

`ifdef SR_FLAG_ARBITER_TOGGLE_EN
    assign w_op_err = 1'b0;
`else
    assign w_op_err = (r_op == OP_BOTH);
`endif

    assign w_err = ~w_in_range | w_op_err;

    // Next flag vector: only the addressed bit may change.
    always_comb begin
        w_next_flags = r_flags;
        for (int unsigned i = 0; i < N_FLAGS; i++) begin
            if (w_in_range && (r_idx == IDX_W'(i))) begin
                case (r_op)
                    OP_CLR:  w_next_flags[i] = 1'b0;
                    OP_SET:  w_next_flags[i] = 1'b1;
`ifdef SR_FLAG_ARBITER_TOGGLE_EN
                    OP_BOTH: w_next_flags[i] = ~r_flags[i];
`else
                    OP_BOTH: w_next_flags[i] = r_flags[i];
`endif
                    OP_HOLD: w_next_flags[i] = r_flags[i];
                    default: w_next_flags[i] = r_flags[i];
                endcase
            end
        end
    end

    // Transaction sequencer: IDLE -> APPLY -> ACK -> RELEASE -> IDLE.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state  <= S_IDLE;
            r_last_b <= 1'b1;
            r_gnt_b  <= 1'b0;
            r_op     <= OP_HOLD;
            r_idx    <= '0;
            r_flags  <= '0;
            r_ack_a  <= 1'b0;
            r_ack_b  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_ack_a <= 1'b0;
            r_ack_b <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_gnt_b  <= w_grant_b;
                        r_last_b <= w_grant_b;
                        r_op     <= w_grant_b ? Op_B : Op_A;
                        r_idx    <= w_grant_b ? Idx_B : Idx_A;
                        r_state  <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    // Ack/Err become visible for exactly the ACK cycle.
                    r_flags <= w_next_flags;
                    r_ack_a <= ~r_gnt_b;
                    r_ack_b <= r_gnt_b;
                    r_err   <= w_err;
                    r_state <= S_ACK;
                end
                S_ACK: begin
                    r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    // The other requester waits until the owner lets go.
                    if (!w_gnt_req) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Ack_A     = r_ack_a;
    assign Ack_B     = r_ack_b;
    assign Err       = r_err;
    assign Flags     = r_flags;
    assign Flags_bar = ~r_flags;
    assign Busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sr_flag_arbiter
// Self-checking bench for sr_flag_arbiter. An 8-flag instance covers the
// handshake, arbitration and reset cases; a 6-flag instance covers the
// out-of-range index case. Expected completions are queued when a request is
// driven and matched against completions recorded on each Ack.
// ----------------------------------------------------------------------------
module tb_sr_flag_arbiter;

    typedef struct packed {
        logic [1:0] src;    // 0: A on 8-flag dut, 1: B on 8-flag dut, 2: A on 6-flag dut, 3: stray Err
        logic [7:0] flags;
        logic       err;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;

    logic       a_req = 1'b0, b_req = 1'b0;
    logic [1:0] a_op = 2'b00, b_op = 2'b00;
    logic [2:0] a_idx = 3'd0, b_idx = 3'd0;
    logic       ack_a, ack_b, err, busy;
    logic [7:0] flags8, fbar8;

    logic       q_req = 1'b0, q_breq = 1'b0;
    logic [1:0] q_op = 2'b00, q_bop = 2'b00;
    logic [2:0] q_idx = 3'd0, q_bidx = 3'd0;
    logic       ack6_a, ack6_b, err6, busy6;
    logic [5:0] flags6, fbar6;

    rec_t sb[$];
    rec_t obs[$];

    sr_flag_arbiter #(.N_FLAGS(8), .IDX_W(3)) u_dut8 (
        .Clk(clk), .Rst_n(rst_n),
        .Req_A(a_req), .Op_A(a_op), .Idx_A(a_idx), .Ack_A(ack_a),
        .Req_B(b_req), .Op_B(b_op), .Idx_B(b_idx), .Ack_B(ack_b),
        .Flags(flags8), .Flags_bar(fbar8), .Err(err), .Busy(busy)
    );

    sr_flag_arbiter #(.N_FLAGS(6), .IDX_W(3)) u_dut6 (
        .Clk(clk), .Rst_n(rst_n),
        .Req_A(q_req), .Op_A(q_op), .Idx_A(q_idx), .Ack_A(ack6_a),
        .Req_B(q_breq), .Op_B(q_bop), .Idx_B(q_bidx), .Ack_B(ack6_b),
        .Flags(flags6), .Flags_bar(fbar6), .Err(err6), .Busy(busy6)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every completion (and any Err without Ack) as it appears.
    always @(negedge clk) begin
        if (ack_a | ack_b | err)
            obs.push_back('{src: ack_b ? 2'd1 : (ack_a ? 2'd0 : 2'd3), flags: flags8, err: err});
        if (ack6_a | ack6_b | err6)
            obs.push_back('{src: ack6_a ? 2'd2 : 2'd3, flags: {2'b00, flags6}, err: err6});
    end

    // Drive one request on the 8-flag dut; call at a negedge. Waits (bounded)
    // for Ack, holds Req a further 'hold' cycles, then drops it.
    task automatic requester(input bit who, input logic [1:0] op, input logic [2:0] idx,
                             input int hold, output int lat, output int ack_cyc, output int drop_cyc);
        lat = 0;
        ack_cyc = -1;
        if (who) begin b_req = 1'b1; b_op = op; b_idx = idx; end
        else     begin a_req = 1'b1; a_op = op; a_idx = idx; end
        while (lat < 40 && ack_cyc < 0) begin
            @(negedge clk);
            lat++;
            if (who ? ack_b : ack_a) ack_cyc = cyc;
        end
        repeat (hold) @(negedge clk);
        if (who) b_req = 1'b0;
        else     a_req = 1'b0;
        drop_cyc = cyc;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (flags8 !== 8'h00) begin n_fail++; $display("FAIL reset_flags8: got %h want 00", flags8); end
        n_cmp++; if (fbar8 !== 8'hFF) begin n_fail++; $display("FAIL reset_fbar8: got %h want FF", fbar8); end
        n_cmp++; if ({ack_a, ack_b, err, busy} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctl8: got ack_a,ack_b,err,busy=%b want 0000", {ack_a, ack_b, err, busy}); end
        n_cmp++; if (fbar6 !== 6'h3F) begin n_fail++; $display("FAIL reset_fbar6: got %h want 3F", fbar6); end
        n_cmp++; if ({flags6, ack6_a, err6, busy6} !== 9'h000) begin
            n_fail++; $display("FAIL reset_ctl6: got flags6=%h ack=%b err=%b busy=%b want all 0", flags6, ack6_a, err6, busy6); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_set_a();
        int lat, ac, dc;
        rec_t e, o;
        sb.push_back('{src: 2'd0, flags: 8'h08, err: 1'b0});
        requester(1'b0, 2'b10, 3'd3, 0, lat, ac, dc);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL set_a_latency: got %0d edges want 2", lat); end
        n_cmp++; if (fbar8 !== 8'hF7) begin n_fail++; $display("FAIL set_a_fbar: got %h want F7", fbar8); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL set_a_busy: got %b want 1", busy); end
        @(negedge clk);
        n_cmp++; if ({ack_a, err} !== 2'b00) begin n_fail++; $display("FAIL set_a_pulse: got ack_a,err=%b want 00", {ack_a, err}); end
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL set_a_idle: got busy=%b want 0", busy); end
        // B hold op: flags unchanged, and B becomes the last grant.
        sb.push_back('{src: 2'd1, flags: 8'h08, err: 1'b0});
        requester(1'b1, 2'b00, 3'd0, 0, lat, ac, dc);
        repeat (3) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs.size() == 0) begin n_fail++; $display("FAIL set_a_sb: no completion, want %h", e); end
            else begin o = obs.pop_front(); if (o !== e) begin n_fail++; $display("FAIL set_a_sb: got %h want %h", o, e); end end
        end
        n_cmp++; if (obs.size() != 0) begin n_fail++; $display("FAIL set_a_extra: got %0d extra completions want 0", obs.size()); obs.delete(); end
    endtask

    task automatic test_tie();
        int la, aa, ad, lb, ab, bd;
        rec_t e, o;
        sb.push_back('{src: 2'd0, flags: 8'h00, err: 1'b0});
        sb.push_back('{src: 2'd1, flags: 8'h01, err: 1'b0});
        fork
            requester(1'b0, 2'b01, 3'd3, 0, la, aa, ad);
            requester(1'b1, 2'b10, 3'd0, 0, lb, ab, bd);
        join
        n_cmp++; if (!(aa >= 0 && ab > aa)) begin n_fail++; $display("FAIL tie_order: got ack_a@%0d ack_b@%0d want a first", aa, ab); end
        repeat (3) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs.size() == 0) begin n_fail++; $display("FAIL tie_sb: no completion, want %h", e); end
            else begin o = obs.pop_front(); if (o !== e) begin n_fail++; $display("FAIL tie_sb: got %h want %h", o, e); end end
        end
        n_cmp++; if (obs.size() != 0) begin n_fail++; $display("FAIL tie_extra: got %0d extra completions want 0", obs.size()); obs.delete(); end
    endtask

    task automatic test_forbidden();
        int lat, ac, dc;
        rec_t e, o;
`ifdef SR_FLAG_ARBITER_TOGGLE_EN
        sb.push_back('{src: 2'd1, flags: 8'h21, err: 1'b0});
`else
        sb.push_back('{src: 2'd1, flags: 8'h01, err: 1'b1});
`endif
        requester(1'b1, 2'b11, 3'd5, 0, lat, ac, dc);
        @(negedge clk);
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL forbidden_err_pulse: got err=%b want 0", err); end
        repeat (3) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs.size() == 0) begin n_fail++; $display("FAIL forbidden_sb: no completion, want %h", e); end
            else begin o = obs.pop_front(); if (o !== e) begin n_fail++; $display("FAIL forbidden_sb: got %h want %h", o, e); end end
        end
        n_cmp++; if (obs.size() != 0) begin n_fail++; $display("FAIL forbidden_extra: got %0d extra completions want 0", obs.size()); obs.delete(); end
    endtask

    task automatic test_range();
        rec_t e, o;
        logic [2:0] idx_tab [2] = '{3'd7, 3'd5};
        logic [7:0] flg_tab [2] = '{8'h00, 8'h20};
        logic       err_tab [2] = '{1'b1, 1'b0};
        for (int t = 0; t < 2; t++) begin
            int n;
            sb.push_back('{src: 2'd2, flags: flg_tab[t], err: err_tab[t]});
            q_req = 1'b1; q_op = 2'b10; q_idx = idx_tab[t];
            n = 0;
            while (n < 40 && !ack6_a) begin @(negedge clk); n++; end
            q_req = 1'b0;
            repeat (4) @(negedge clk);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs.size() == 0) begin n_fail++; $display("FAIL range_sb: no completion, want %h", e); end
            else begin o = obs.pop_front(); if (o !== e) begin n_fail++; $display("FAIL range_sb: got %h want %h", o, e); end end
        end
        n_cmp++; if (obs.size() != 0) begin n_fail++; $display("FAIL range_extra: got %0d extra completions want 0", obs.size()); obs.delete(); end
    endtask

    task automatic test_reset_apply();
        int lat, ac, dc;
        rec_t e, o;
        a_req = 1'b1; a_op = 2'b10; a_idx = 3'd2;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (flags8 !== 8'h00) begin n_fail++; $display("FAIL rst_apply_flags: got %h want 00", flags8); end
        n_cmp++; if ({ack_a, busy} !== 2'b00) begin n_fail++; $display("FAIL rst_apply_ctl: got ack_a,busy=%b want 00", {ack_a, busy}); end
        a_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (obs.size() != 0) begin n_fail++; $display("FAIL rst_apply_noack: got %0d completions want 0", obs.size()); obs.delete(); end
        n_cmp++; if (fbar8 !== 8'hFF) begin n_fail++; $display("FAIL rst_apply_fbar: got %h want FF", fbar8); end
        sb.push_back('{src: 2'd0, flags: 8'h04, err: 1'b0});
        requester(1'b0, 2'b10, 3'd2, 0, lat, ac, dc);
        repeat (3) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs.size() == 0) begin n_fail++; $display("FAIL rst_apply_sb: no completion, want %h", e); end
            else begin o = obs.pop_front(); if (o !== e) begin n_fail++; $display("FAIL rst_apply_sb: got %h want %h", o, e); end end
        end
    endtask

    task automatic test_back_to_back();
        int la, aa, ad, lb, ab, bd;
        rec_t e, o;
        sb.push_back('{src: 2'd0, flags: 8'h44, err: 1'b0});
        sb.push_back('{src: 2'd1, flags: 8'h40, err: 1'b0});
        fork
            requester(1'b0, 2'b10, 3'd6, 3, la, aa, ad);
            begin @(negedge clk); requester(1'b1, 2'b01, 3'd2, 0, lb, ab, bd); end
        join
        // A drops after edge P; IDLE at P+1, grant B at P+2, B acked after P+3.
        n_cmp++; if (ab - ad !== 3) begin n_fail++; $display("FAIL b2b_wait: got ack_b %0d edges after A release want 3", ab - ad); end
        repeat (3) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs.size() == 0) begin n_fail++; $display("FAIL b2b_sb: no completion, want %h", e); end
            else begin o = obs.pop_front(); if (o !== e) begin n_fail++; $display("FAIL b2b_sb: got %h want %h", o, e); end end
        end
        n_cmp++; if (obs.size() != 0) begin n_fail++; $display("FAIL b2b_extra: got %0d extra completions want 0", obs.size()); obs.delete(); end
    endtask

    initial begin
        test_reset();
        test_set_a();
        test_tie();
        test_forbidden();
        test_range();
        test_reset_apply();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion of the sequence, want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
